// File: rtl/pa_pkg.sv
// Shared definitions for the pipelined parallel adder.
//
// Holds the default operand/segment widths, the derivation of the pipeline
// depth from those widths and the legality check applied at elaboration by
// the top level. No ports; imported by every file of the adder.

package pa_pkg;

  // Default operand width and bits handled per pipeline stage.
  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefSeg   = 4;

  // Number of segment stages for a given operand width and segment width.
  // An illegal combination still yields at least one stage so that the
  // enclosing design elaborates far enough to report the real problem.
  function automatic int unsigned calc_stages(int unsigned width, int unsigned seg);
    if (seg == 0 || width < seg) begin
      return 1;
    end
    return width / seg;
  endfunction

  // A width is legal when it is a non-zero whole number of segments.
  function automatic bit seg_ok(int unsigned width, int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry adder slice.
//
// Ports:
//   a, b   - SEG-bit operand slices (b already inverted for subtraction)
//   ci     - carry into bit 0 of the slice
//   s      - SEG-bit sum of the slice
//   co     - carry out of the top bit of the slice
//   c_msb  - carry into the top bit of the slice; together with co it gives
//            signed overflow when this slice holds the operand MSB

module adder_segment
  import pa_pkg::*;
#(
  parameter int unsigned SEG = DefSeg
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  always_comb begin
    logic carry;
    carry = ci;
    s     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) begin
        c_msb = carry;
      end
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_parallel_adder.sv
// Pipelined WIDTH-bit adder/subtractor built from SEG-bit ripple segments.
//
// One segment of the carry chain is resolved per pipeline stage, so an
// operation accepted on edge n is presented on the output after edge
// n+STAGES. A single advance signal moves every stage at once, so bubbles
// are carried along rather than squeezed out, and a stalled output freezes
// the whole pipe.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset; drops every in-flight op
//   in_valid   - operands on A/B/cin/sub are valid
//   in_ready   - adder will take the operands on the next rising edge
//   A, B       - WIDTH-bit operands
//   cin        - carry in for addition, ignored when sub=1
//   sub        - 0: A+B+cin, 1: A-B
//   out_valid  - s/cout/ovf hold a result
//   out_ready  - consumer takes the result on the next rising edge
//   s          - WIDTH-bit sum or difference, modulo 2^WIDTH
//   cout       - carry out of the MSB; for subtraction 1 means no borrow
//   ovf        - two's complement overflow

module pipelined_parallel_adder
  import pa_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG   = DefSeg
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("pipelined_parallel_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Every register in the pipe moves together; only a held result blocks.
  logic adv;
  logic out_vld_q;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  // Stage k feeds segment k of the carry chain. Its register holds the
  // valid bit, the carry into segment k, the sum bits already resolved by
  // earlier stages and the operand bits from segment k upwards. Lower
  // operand bits are dropped once they have been summed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * SEG;
    localparam int unsigned Hi = WIDTH - Lo;

    logic            vld_q;
    logic            c_q;
    logic [Hi-1:0]   a_q;
    logic [Hi-1:0]   b_q;
    logic [SEG-1:0]  seg_s;
    logic            seg_co;
    logic            seg_cmsb;
    // Sum bits resolved up to and including this stage's segment.
    logic [Lo+SEG-1:0] done;

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a     (a_q[SEG-1:0]),
      .b     (b_q[SEG-1:0]),
      .ci    (c_q),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cmsb)
    );

    if (k == 0) begin : g_load
      // Subtraction is A + ~B + 1: invert B here and force the carry in.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (adv) begin
          vld_q <= in_valid;
          c_q   <= sub | cin;
          a_q   <= A;
          b_q   <= sub ? ~B : B;
        end
      end

      assign done = seg_s;
    end else begin : g_load
      logic [Lo-1:0] sum_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
        end else if (adv) begin
          vld_q <= g_stage[k-1].vld_q;
          c_q   <= g_stage[k-1].seg_co;
          a_q   <= g_stage[k-1].a_q[Hi+SEG-1:SEG];
          b_q   <= g_stage[k-1].b_q[Hi+SEG-1:SEG];
          sum_q <= g_stage[k-1].done;
        end
      end

      assign done = {seg_s, sum_q};
    end

    // The carry into a segment's top bit only matters at the operand MSB.
    if (k != STAGES - 1) begin : g_cmsb_sink
      logic unused_cmsb;
      assign unused_cmsb = seg_cmsb;
    end
  end

  // Output register: full result plus the two MSB carries for overflow.
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             cmsb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      s_q       <= '0;
      cout_q    <= 1'b0;
      cmsb_q    <= 1'b0;
    end else if (adv) begin
      out_vld_q <= g_stage[STAGES-1].vld_q;
      s_q       <= g_stage[STAGES-1].done;
      cout_q    <= g_stage[STAGES-1].seg_co;
      cmsb_q    <= g_stage[STAGES-1].seg_cmsb;
    end
  end

  assign out_valid = out_vld_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = cout_q ^ cmsb_q;

endmodule
